// File: rtl/fc_input_sequencer.sv
// fc_input_sequencer
//   Walks the input activations of one fully-connected layer pass. For each
//   input index k it fetches weight row k from memory, pairs it with
//   activation k and presents the pair as one beat to the MAC array, using a
//   valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request one pass (accepted only when idle)
//   in_vector         flattened activations, element k at
//                     [(INPUT_NODES-1-k)*DATA_WIDTH +: DATA_WIDTH]
//   mem_en            weight-memory read enable
//   mem_address       weight-memory row index (current k)
//   mem_weights       row data, valid one clock after the address is sampled
//   mac_valid/ready   beat handshake to the MAC array
//   mac_activation    activation k of the current beat
//   mac_weights       weight row k of the current beat
//   mac_first/last    beat markers for k==0 / k==INPUT_NODES-1
//   busy              high whenever not idle
//   done              one-cycle pulse at pass completion
module fc_input_sequencer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned INPUT_NODES  = 100,
  parameter int unsigned OUTPUT_NODES = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [DATA_WIDTH*INPUT_NODES-1:0]  in_vector,
  output logic                               mem_en,
  output logic [10:0]                        mem_address,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] mem_weights,
  output logic                               mac_valid,
  input  logic                               mac_ready,
  output logic [DATA_WIDTH-1:0]              mac_activation,
  output logic [DATA_WIDTH*OUTPUT_NODES-1:0] mac_weights,
  output logic                               mac_first,
  output logic                               mac_last,
  output logic                               busy,
  output logic                               done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PRESENT,
    ST_DONE
  } state_t;

  localparam logic [10:0] LAST_K = 11'(INPUT_NODES - 1);

  state_t                            state_q, state_d;
  logic [10:0]                       k_q, k_d;
  logic [DATA_WIDTH-1:0]             act_q, act_d;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0] wts_q, wts_d;
  logic [DATA_WIDTH-1:0]             act_sel;

  // Activation k out of the flattened vector (element 0 sits in the MSBs).
  always_comb begin
    act_sel = '0;
    for (int unsigned i = 0; i < INPUT_NODES; i++) begin
      if (k_q == 11'(i)) begin
        act_sel = in_vector[(INPUT_NODES-1-i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    act_d   = act_q;
    wts_d   = wts_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d     = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        // Memory data for row k is valid during this cycle.
        act_d   = act_sel;
        wts_d   = mem_weights;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (mac_ready) begin
          if (k_q == LAST_K) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + 11'd1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      act_q   <= '0;
      wts_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      act_q   <= act_d;
      wts_q   <= wts_d;
    end
  end

  // Outputs decode directly from registered state so reset clears them at once.
  always_comb begin
    mem_en         = (state_q == ST_FETCH);
    mem_address    = k_q;
    mac_valid      = (state_q == ST_PRESENT);
    mac_first      = (state_q == ST_PRESENT) && (k_q == '0);
    mac_last       = (state_q == ST_PRESENT) && (k_q == LAST_K);
    mac_activation = act_q;
    mac_weights    = wts_q;
    busy           = (state_q != ST_IDLE);
    done           = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_fc_input_sequencer.sv
// Bench for fc_input_sequencer with INPUT_NODES=4: reset state, beat timing,
// beat contents through a scoreboard, backpressure, ignored starts and
// mid-pass reset.
module tb_fc_input_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned IN = 4;
  localparam int unsigned ON = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [DW*IN-1:0]    in_vector;
  logic                mem_en;
  logic [10:0]         mem_address;
  logic [DW*ON-1:0]    mem_weights;
  logic                mac_valid;
  logic                mac_ready;
  logic [DW-1:0]       mac_activation;
  logic [DW*ON-1:0]    mac_weights;
  logic                mac_first;
  logic                mac_last;
  logic                busy;
  logic                done;

  typedef struct {
    logic [DW-1:0]    act;
    logic [DW*ON-1:0] wts;
    logic             first;
    logic             last;
    logic [10:0]      addr;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    done_total = 0;

  fc_input_sequencer #(
    .DATA_WIDTH  (DW),
    .INPUT_NODES (IN),
    .OUTPUT_NODES(ON)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_vector     (in_vector),
    .mem_en        (mem_en),
    .mem_address   (mem_address),
    .mem_weights   (mem_weights),
    .mac_valid     (mac_valid),
    .mac_ready     (mac_ready),
    .mac_activation(mac_activation),
    .mac_weights   (mac_weights),
    .mac_first     (mac_first),
    .mac_last      (mac_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Weight memory: row k is every word equal to k, one clock read latency.
  initial mem_weights = '0;
  always @(posedge clk) begin
    if (mem_en) mem_weights <= {ON{DW'(mem_address)}};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: compare each handshaken beat with the next expected one.
  always @(negedge clk) begin
    beat_t e;
    #1;
    if (rst_n && mac_valid && mac_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("beat_act",   64'(mac_activation), 64'(e.act));
        check("beat_wts",   64'(mac_weights),    64'(e.wts));
        check("beat_first", 64'(mac_first),      64'(e.first));
        check("beat_last",  64'(mac_last),       64'(e.last));
        check("beat_addr",  64'(mem_address),    64'(e.addr));
      end
    end
    if (rst_n && done) done_total++;
  end

  task automatic push_beats(input int unsigned n);
    beat_t b;
    for (int unsigned k = 0; k < n; k++) begin
      b.act   = DW'(16'h100 + k);
      b.wts   = {ON{DW'(k)}};
      b.first = (k == 0);
      b.last  = (k == IN - 1);
      b.addr  = 11'(k);
      sb.push_back(b);
    end
  endtask

  // One pass; cycle c is the c-th clock period after the start edge.
  task automatic run_pass(input int stall_at, input int stall_len, input bit extra_starts);
    int            done_cycle;
    int            done_cnt;
    logic [10:0]   s_addr;
    logic [DW-1:0] s_act;
    logic [DW*ON-1:0] s_wts;
    done_cycle = -1;
    done_cnt   = 0;
    s_addr = '0; s_act = '0; s_wts = '0;
    push_beats(IN);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (stall_len == 0 && c <= 14) begin
        check("t_mem_en",    64'(mem_en),    64'((c % 3 == 1) && c <= 10));
        check("t_mac_valid", 64'(mac_valid), 64'((c % 3 == 0) && c <= 12));
        check("t_first",     64'(mac_first), 64'(c == 3));
        check("t_last",      64'(mac_last),  64'(c == 12));
        check("t_busy",      64'(busy),      64'(c <= 13));
        if (c % 3 == 1 && c <= 10) check("t_mem_addr", 64'(mem_address), 64'((c - 1) / 3));
      end
      if (stall_len != 0 && c == stall_at) begin
        s_addr = mem_address; s_act = mac_activation; s_wts = mac_weights;
        check("bp_valid0", 64'(mac_valid), 64'd1);
      end
      if (stall_len != 0 && c > stall_at && c <= stall_at + stall_len) begin
        check("bp_valid", 64'(mac_valid),      64'd1);
        check("bp_addr",  64'(mem_address),    64'(s_addr));
        check("bp_act",   64'(mac_activation), 64'(s_act));
        check("bp_wts",   64'(mac_weights),    64'(s_wts));
      end
      mac_ready = !(stall_len != 0 && c >= stall_at && c < stall_at + stall_len);
      start = extra_starts && (c == 1 || c == 3 || c == 13);
    end
    start = 1'b0;
    check("done_count", 64'(done_cnt), 64'd1);
    check("done_cycle", 64'(done_cycle), 64'(13 + stall_len));
    check("idle_busy",  64'(busy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_mem_en"},   64'(mem_en),         64'd0);
    check({pfx, "_mem_addr"}, 64'(mem_address),    64'd0);
    check({pfx, "_valid"},    64'(mac_valid),      64'd0);
    check({pfx, "_act"},      64'(mac_activation), 64'd0);
    check({pfx, "_wts"},      64'(mac_weights),    64'd0);
    check({pfx, "_first"},    64'(mac_first),      64'd0);
    check({pfx, "_last"},     64'(mac_last),       64'd0);
    check({pfx, "_busy"},     64'(busy),           64'd0);
    check({pfx, "_done"},     64'(done),           64'd0);
  endtask

  initial begin
    int done_before;
    rst_n     = 1'b0;
    start     = 1'b0;
    mac_ready = 1'b1;
    in_vector = '0;
    for (int unsigned k = 0; k < IN; k++) in_vector[(IN-1-k)*DW +: DW] = DW'(16'h100 + k);

    // Reset, then idle with start low.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_all_zero("idle");

    // Nominal timing and data.
    run_pass(0, 0, 1'b0);
    // Backpressure on the k=1 beat (cycle 6) for 5 cycles.
    run_pass(6, 5, 1'b0);
    // Starts pulsed in FETCH, PRESENT and DONE are ignored.
    run_pass(0, 0, 1'b1);

    // Mid-pass reset while presenting k=2.
    push_beats(2);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 9) mac_ready = 1'b0;
    end
    check("pre_rst_valid", 64'(mac_valid),   64'd1);
    check("pre_rst_addr",  64'(mem_address), 64'd2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    done_before = done_total;
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    mac_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_done", 64'(done_total), 64'(done_before));
    check("rst_sb",      64'(sb.size()),  64'd0);
    run_pass(0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
